// File: rtl/sar_search_8b_pkg.sv
// Shared constants and sizing helpers for the successive-approximation search engine.
package sar_search_8b_pkg;

    // FSM state encoding
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_TEST   = 2'd1;
    localparam logic [1:0] ST_FINISH = 2'd2;

    // Default operand width
    localparam int unsigned DEFAULT_W = 8;

    // Width of the bit-index register for a W-bit search (W >= 2)
    function automatic int unsigned idx_width(input int unsigned w);
        return (w > 2) ? $clog2(w) : 1;
    endfunction

    // Width of the comparator wait counter; at least one bit even for a zero-latency comparator
    function automatic int unsigned cnt_width(input int unsigned lat);
        return (lat > 0) ? $clog2(lat + 1) : 1;
    endfunction

endpackage

// File: rtl/sar_search_8b_trial_gen.sv
// Combinational bit arithmetic for one successive-approximation step:
// folds the sampled compare result into the accumulator and forms the next
// comparator operand (trial value minus one, so a strict '>' compare tests '>=').
module sar_trial_gen
    import sar_search_8b_pkg::*;
#(
    parameter int unsigned W  = DEFAULT_W,
    parameter int unsigned KW = idx_width(DEFAULT_W)
) (
    input  logic [W-1:0]  acc,
    input  logic [KW-1:0] k,
    input  logic          y_sampled,
    output logic [W-1:0]  next_acc_c,
    output logic [W-1:0]  next_cmp_b_c
);

    logic [W-1:0]  trial;
    logic [KW-1:0] k_low;

    // Accept or reject bit k, then build the operand for bit k-1
    always_comb begin
        trial        = '0;
        k_low        = '0;
        next_acc_c   = '0;
        next_cmp_b_c = '0;

        trial      = acc | (W'(1) << k);
        next_acc_c = y_sampled ? trial : acc;

        // At k == 0 the next operand is unused; clamp the index to stay in range
        k_low        = (k != '0) ? (k - KW'(1)) : '0;
        next_cmp_b_c = (next_acc_c | (W'(1) << k_low)) - W'(1);
    end

endmodule

// File: rtl/sar_search_8b.sv
// Successive-approximation search engine: drives a magnitude comparator's
// b operand and recovers the W-bit target on its a operand in W steps.
// Each step waits CMP_LAT cycles for the comparator before sampling cmp_y.
module sar_search_8b
    import sar_search_8b_pkg::*;
#(
    parameter int unsigned W       = DEFAULT_W,
    parameter int unsigned CMP_LAT = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    output logic [W-1:0] cmp_b,
    input  logic         cmp_y,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] result
);

    localparam int unsigned KW = idx_width(W);
    localparam int unsigned CW = cnt_width(CMP_LAT);

    // Operand for the first (MSB) trial: 2^(W-1) - 1
    localparam logic [W-1:0] FIRST_B = {1'b0, {(W-1){1'b1}}};

    logic [1:0]    state,    state_nxt;
    logic [W-1:0]  acc,      acc_nxt;
    logic [KW-1:0] k,        k_nxt;
    logic [CW-1:0] wait_cnt, wait_cnt_nxt;
    logic [W-1:0]  cmp_b_nxt;
    logic          busy_nxt;
    logic          done_nxt;
    logic [W-1:0]  result_nxt;

    logic [W-1:0]  gen_acc_c;
    logic [W-1:0]  gen_cmp_b_c;

    // Per-step accumulator update and next operand
    sar_trial_gen #(
        .W  (W),
        .KW (KW)
    ) u_trial_gen (
        .acc          (acc),
        .k            (k),
        .y_sampled    (cmp_y),
        .next_acc_c   (gen_acc_c),
        .next_cmp_b_c (gen_cmp_b_c)
    );

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            acc      <= '0;
            k        <= KW'(W - 1);
            wait_cnt <= '0;
            cmp_b    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            result   <= '0;
        end else begin
            state    <= state_nxt;
            acc      <= acc_nxt;
            k        <= k_nxt;
            wait_cnt <= wait_cnt_nxt;
            cmp_b    <= cmp_b_nxt;
            busy     <= busy_nxt;
            done     <= done_nxt;
            result   <= result_nxt;
        end
    end

    // Next-state and next-output decode
    always_comb begin
        state_nxt    = state;
        acc_nxt      = acc;
        k_nxt        = k;
        wait_cnt_nxt = wait_cnt;
        cmp_b_nxt    = cmp_b;
        busy_nxt     = busy;
        done_nxt     = 1'b0;
        result_nxt   = result;

        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt    = ST_TEST;
                    acc_nxt      = '0;
                    k_nxt        = KW'(W - 1);
                    wait_cnt_nxt = CW'(CMP_LAT);
                    cmp_b_nxt    = FIRST_B;
                    busy_nxt     = 1'b1;
                end
            end

            ST_TEST: begin
                if (wait_cnt != '0) begin
                    // Comparator still settling; hold the operand
                    wait_cnt_nxt = wait_cnt - CW'(1);
                end else begin
                    acc_nxt = gen_acc_c;
                    if (k != '0) begin
                        k_nxt        = k - KW'(1);
                        wait_cnt_nxt = CW'(CMP_LAT);
                        cmp_b_nxt    = gen_cmp_b_c;
                    end else begin
                        state_nxt  = ST_FINISH;
                        result_nxt = gen_acc_c;
                        done_nxt   = 1'b1;
                        busy_nxt   = 1'b0;
                    end
                end
            end

            ST_FINISH: begin
                // start is ignored here; a request must be seen in IDLE
                state_nxt = ST_IDLE;
            end

            default: begin
                state_nxt = ST_IDLE;
                busy_nxt  = 1'b0;
            end
        endcase
    end

endmodule
